// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle, one-at-a-time load/store responder with a big-endian byte store.
// Requests are checked at acceptance, and the access happens on the edge where BUSY ends.
`timescale 1ns/1ps
`default_nettype none

module dmem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [3:0]             cnt, cnt_next;
  logic                   write_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [63:0]            wdata_q;
  logic [3:0]             size_q;
  logic                   err_q;
  logic [7:0]             mem [DEPTH];

  logic                   accept;
  logic                   finish;
  logic                   req_bad;
  logic                   size_ok;
  logic                   align_ok;
  logic                   range_ok;
  logic [63:0]            load_data;
  logic [7:0]             store_byte [8];

  assign accept = req_valid & req_ready;
  assign finish = (state == BUSY) && (cnt == 4'd0);

  // Range check is done with one extra bit so addr+size cannot wrap.
  always_comb begin
    size_ok  = (req_size == 4'd1) || (req_size == 4'd2) ||
               (req_size == 4'd4) || (req_size == 4'd8);
    align_ok = ((req_addr[3:0] & (req_size - 4'd1)) == 4'd0);
    range_ok = (req_addr[63:ADDR_BITS] == '0) &&
               (({1'b0, req_addr[ADDR_BITS-1:0]} + (ADDR_BITS+1)'(req_size))
                 <= (ADDR_BITS+1)'(DEPTH));
    req_bad  = !(size_ok && align_ok && range_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (accept) begin
          state_next = BUSY;
          cnt_next   = 4'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_next = RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 64'd0;
      size_q  <= 4'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr[ADDR_BITS-1:0];
      wdata_q <= req_wdata;
      size_q  <= req_size;
      err_q   <= req_bad;
    end
  end

  // Lowest address is shifted in first, so it lands in the most significant used byte.
  always_comb begin
    load_data = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < size_q)
        load_data = {load_data[55:0], mem[addr_q + ADDR_BITS'(i)]};
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      store_byte[i] = 8'(wdata_q >> {size_q[2:0] - 3'(i) - 3'd1, 3'b000});
    end
  end

  always_ff @(posedge clk) begin
    if (finish && !reset && !err_q && write_q) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < size_q)
          mem[addr_q + ADDR_BITS'(i)] <= store_byte[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_rdata <= 64'd0;
      resp_error <= 1'b0;
    end else if (finish) begin
      resp_error <= err_q;
      resp_rdata <= (err_q || write_q) ? 64'd0 : load_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder (ADDR_BITS=10, LATENCY=3).
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_size;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_error;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_BITS(10), .LATENCY(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error)
  );

  typedef struct packed {
    logic        err;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag, output bit ok);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) check({tag, " accept timeout"}, {63'd0, req_ready}, 64'd1);
  endtask

  task automatic xact(input string tag, input logic w, input logic [63:0] a,
                      input logic [63:0] d, input logic [3:0] sz,
                      input logic [63:0] exp_data, input logic exp_err);
    exp_t e;
    int   n;
    bit   ok;
    e.err  = exp_err;
    e.data = exp_data;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_size  = sz;
    wait_ready(tag, ok);
    if (!ok) begin
      req_valid = 1'b0;
      void'(sb.pop_back());
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd3);
    e = sb.pop_front();
    check({tag, " rdata"}, resp_rdata, e.data);
    check({tag, " error"}, {63'd0, resp_error}, {63'd0, e.err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] hold;
    bit          ok;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 64'd0;
    req_wdata  = 64'd0;
    req_size   = 4'd0;
    resp_ready = 1'b1;

    repeat (4) begin
      @(posedge clk);
      #1;
      check("rst req_ready", {63'd0, req_ready}, 64'd0);
      check("rst resp_valid", {63'd0, resp_valid}, 64'd0);
      check("rst resp_rdata", resp_rdata, 64'd0);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 check("post-rst req_ready", {63'd0, req_ready}, 64'd1);

    xact("st8 0x10", 1'b1, 64'h10, 64'h0123456789ABCDEF, 4'd8, 64'd0, 1'b0);
    xact("ld8 0x10", 1'b0, 64'h10, 64'd0, 4'd8, 64'h0123456789ABCDEF, 1'b0);
    xact("ld1 0x10", 1'b0, 64'h10, 64'd0, 4'd1, 64'h01, 1'b0);
    xact("ld2 0x16", 1'b0, 64'h16, 64'd0, 4'd2, 64'hCDEF, 1'b0);
    xact("ld4 0x14", 1'b0, 64'h14, 64'd0, 4'd4, 64'h89ABCDEF, 1'b0);

    xact("ld4 misalign", 1'b0, 64'h12, 64'd0, 4'd4, 64'd0, 1'b1);
    xact("ld size3", 1'b0, 64'h10, 64'd0, 4'd3, 64'd0, 1'b1);
    xact("st2 misalign", 1'b1, 64'h11, 64'hFFFF, 4'd2, 64'd0, 1'b1);
    xact("st8 0x3F8", 1'b1, 64'h3F8, 64'h1122334455667788, 4'd8, 64'd0, 1'b0);
    xact("st8 0x400", 1'b1, 64'h400, 64'hFFFFFFFFFFFFFFFF, 4'd8, 64'd0, 1'b1);
    xact("st8 high addr", 1'b1, 64'h8000_0000_0000_03F8, 64'hFFFFFFFFFFFFFFFF, 4'd8, 64'd0, 1'b1);
    xact("ld8 0x3F8", 1'b0, 64'h3F8, 64'd0, 4'd8, 64'h1122334455667788, 1'b0);
    xact("st1 0x3FF", 1'b1, 64'h3FF, 64'h5A, 4'd1, 64'd0, 1'b0);
    xact("ld4 0x3FC", 1'b0, 64'h3FC, 64'd0, 4'd4, 64'h5566775A, 1'b0);
    xact("ld8 0x10 again", 1'b0, 64'h10, 64'd0, 4'd8, 64'h0123456789ABCDEF, 1'b0);

    // Backpressure: hold off the consumer for five cycles in RESP.
    xact("bp ld2 0x10", 1'b0, 64'h10, 64'd0, 4'd2, 64'h0123, 1'b0);
    resp_ready = 1'b0;
    hold = resp_rdata;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp resp_valid", {63'd0, resp_valid}, 64'd1);
      check("bp resp_rdata", resp_rdata, hold);
      check("bp req_ready", {63'd0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release resp_valid", {63'd0, resp_valid}, 64'd0);
    check("bp release req_ready", {63'd0, req_ready}, 64'd1);
    xact("bp next ld1 0x17", 1'b0, 64'h17, 64'd0, 4'd1, 64'hEF, 1'b0);

    // Reset landing on the store's write edge must cancel the write.
    xact("st8 0x20", 1'b1, 64'h20, 64'hAABBCCDD11223344, 4'd8, 64'd0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h20;
    req_wdata = 64'hDEADBEEFCAFEF00D;
    req_size  = 4'd8;
    wait_ready("midrst", ok);
    if (ok) begin
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("midrst busy resp_valid", {63'd0, resp_valid}, 64'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midrst req_ready in reset", {63'd0, req_ready}, 64'd0);
      check("midrst resp_valid", {63'd0, resp_valid}, 64'd0);
      reset = 1'b0;
      #1 check("midrst idle req_ready", {63'd0, req_ready}, 64'd1);
    end else begin
      req_valid = 1'b0;
    end
    xact("midrst ld8 0x20", 1'b0, 64'h20, 64'd0, 4'd8, 64'hAABBCCDD11223344, 1'b0);
    xact("midrst ld4 0x24", 1'b0, 64'h24, 64'd0, 4'd4, 64'h11223344, 1'b0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
